// File: rtl/meas_pkg.sv
// -----------------------------------------------------------------------------
// meas_pkg
// Shared definitions for the measurement sequencer that drives the log-scale
// event counter (7-bit base, 4-bit exponent).
//   - meas_state_t : sequencer states
//   - BASE_W/EXP_W : counter field widths
//   - BASE_SAT     : base value reported when the counter range is exceeded
//   - is_result_state() : true in the states that offer a result downstream
// -----------------------------------------------------------------------------
package meas_pkg;

  localparam int BASE_W = 7;
  localparam int EXP_W  = 4;
  localparam logic [BASE_W-1:0] BASE_SAT = 7'd99;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    LATCH   = 3'd3,
    PRESENT = 3'd4,
    OVFL    = 3'd5
  } meas_state_t;

  // States in which result_valid is offered to the display path.
  function automatic logic is_result_state(input meas_state_t s);
    return (s == PRESENT) || (s == OVFL);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler that turns the system clock into one-cycle counter-enable ticks.
// Parameter PRESCALE (>= 1): clk cycles per tick.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  zero the prescaler (asserted the cycle before counting starts)
//   run   in  count enable; tick only appears while run is high
//   tick  out high on the last cycle of every PRESCALE-cycle window
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_r;

  // Prescale counter: wraps at PRE_LAST, holds when not running.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre_r <= '0;
    end else if (run) begin
      if (pre_r == PRE_LAST) begin
        pre_r <= '0;
      end else begin
        pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  // With PRESCALE=1 PRE_LAST is 0, so every running cycle ticks.
  assign tick = run && (pre_r == PRE_LAST);

endmodule

// File: rtl/meas_ctrl.sv
// -----------------------------------------------------------------------------
// meas_ctrl
// Measurement sequencer: clears and arms the log-scale counter, gates its
// enable through a prescaled tick, stops on request or on exponent overflow,
// and hands the frozen base/exponent to the display path via valid/ready.
// Parameters: PRESCALE (clk cycles per count, >= 1), MAX_EXP (highest legal
// exponent).
// Optional feature macro: MEAS_CTRL_AUTO_REARM_EN -- when defined, an accepted
// result re-arms straight into CLEAR for back-to-back measurements.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, stop               single-cycle control pulses
//   base_in, exponent_in      live counter value
//   cnt_en, cnt_rst           counter enable tick / counter clear
//   result_base, result_exp   frozen result
//   result_valid, result_ready  result handshake
//   overflow                  result is saturated
//   busy                      sequencer not idle
// -----------------------------------------------------------------------------
module meas_ctrl
  import meas_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int MAX_EXP  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [BASE_W-1:0] base_in,
  input  logic [EXP_W-1:0]  exponent_in,
  output logic              cnt_en,
  output logic              cnt_rst,
  output logic [BASE_W-1:0] result_base,
  output logic [EXP_W-1:0]  result_exp,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow,
  output logic              busy
);

  localparam logic [EXP_W-1:0] MAX_EXP_C = EXP_W'(MAX_EXP);

`ifdef MEAS_CTRL_AUTO_REARM_EN
  localparam meas_state_t DONE_NEXT = CLEAR;
`else
  localparam meas_state_t DONE_NEXT = IDLE;
`endif

  meas_state_t       state_r;
  meas_state_t       state_nxt_s;
  logic              ovf_s;
  logic              handshake_s;
  logic              valid_r;
  logic              busy_r;
  logic              overflow_r;
  logic [BASE_W-1:0] base_r;
  logic [EXP_W-1:0]  exp_r;

  assign ovf_s       = (exponent_in > MAX_EXP_C);
  assign handshake_s = valid_r && result_ready;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state_r == CLEAR),
    .run   (state_r == RUN),
    .tick  (cnt_en)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; overflow outranks a coincident stop in RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: state_nxt_s = RUN;
      RUN: begin
        if (ovf_s) begin
          state_nxt_s = OVFL;
        end else if (stop) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LATCH: state_nxt_s = PRESENT;
      PRESENT, OVFL: begin
        if (handshake_s) begin
          state_nxt_s = DONE_NEXT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Registered status flags, derived from the upcoming state so they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= is_result_state(state_nxt_s);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Result capture: saturate on overflow, sample the counter when leaving
  // LATCH, and hold everything stable while the result waits for acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r     <= '0;
      exp_r      <= '0;
      overflow_r <= 1'b0;
    end else if ((state_r == RUN) && ovf_s) begin
      base_r     <= BASE_SAT;
      exp_r      <= MAX_EXP_C;
      overflow_r <= 1'b1;
    end else if (state_r == LATCH) begin
      base_r     <= base_in;
      exp_r      <= exponent_in;
      overflow_r <= 1'b0;
    end else if (handshake_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign cnt_rst      = rst || (state_r == CLEAR);
  assign result_valid = valid_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign result_base  = base_r;
  assign result_exp   = exp_r;

endmodule

// File: tb/tb_meas_ctrl.sv
// -----------------------------------------------------------------------------
// tb_meas_ctrl
// Directed bench for meas_ctrl with PRESCALE=4, MAX_EXP=9. A behavioural
// log-scale counter drives base_in/exponent_in; a stub override can force the
// exponent to provoke overflow.
// -----------------------------------------------------------------------------
module tb_meas_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [6:0] base_in;
  logic [3:0] exponent_in;
  logic       cnt_en;
  logic       cnt_rst;
  logic [6:0] result_base;
  logic [3:0] result_exp;
  logic       result_valid;
  logic       result_ready;
  logic       overflow;
  logic       busy;

  logic [6:0] ctr_base;
  logic [3:0] ctr_exp;
  logic       stub_en;
  logic [3:0] stub_exp;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  meas_ctrl #(
    .PRESCALE (4),
    .MAX_EXP  (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .base_in      (base_in),
    .exponent_in  (exponent_in),
    .cnt_en       (cnt_en),
    .cnt_rst      (cnt_rst),
    .result_base  (result_base),
    .result_exp   (result_exp),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  // Counter model: base 0..99, rolls over to 10 with exponent increment.
  always @(posedge clk) begin
    if (cnt_rst) begin
      ctr_base <= 7'd0;
      ctr_exp  <= 4'd0;
    end else if (cnt_en) begin
      if (ctr_base == 7'd99) begin
        ctr_base <= 7'd10;
        ctr_exp  <= ctr_exp + 4'd1;
      end else begin
        ctr_base <= ctr_base + 7'd1;
      end
    end
  end

  assign base_in     = ctr_base;
  assign exponent_in = stub_en ? stub_exp : ctr_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until n further cnt_en pulses are seen (bounded).
  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int c = 0; c < 400 && seen < n; c++) begin
      step();
      if (cnt_en) seen++;
    end
    check_eq("tick_wait", seen, n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; result_ready = 1'b0;
    stub_en = 1'b0; stub_exp = 4'd0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_cnt_rst", cnt_rst, 1);
      check_eq("rst_busy", busy, 0);
    end
    check_eq("rst_cnt_en", cnt_en, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_base", result_base, 0);
    check_eq("rst_exp", result_exp, 0);
    check_eq("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_cnt_rst", cnt_rst, 0);
    check_eq("post_rst_busy", busy, 0);

    // stop in IDLE is ignored.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("idle_stop_busy", busy, 0);

    // Start, first tick after PRESCALE RUN cycles, stop after 12th tick.
    pulse_start();
    check_eq("clr_cnt_rst", cnt_rst, 1);
    check_eq("clr_busy", busy, 1);
    step(); check_eq("run0_en", cnt_en, 0);
    step(); check_eq("run1_en", cnt_en, 0);
    step(); check_eq("run2_en", cnt_en, 0);
    step(); check_eq("first_en", cnt_en, 1);
    check_eq("first_en_cnt_rst", cnt_rst, 0);
    wait_ticks(11);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("latch_valid", result_valid, 0);
    step();
    check_eq("stop_valid", result_valid, 1);
    check_eq("stop_base", result_base, 12);
    check_eq("stop_exp", result_exp, 0);
    check_eq("stop_ovf", overflow, 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_eq("hs1_valid", result_valid, 0);
`ifndef MEAS_CTRL_AUTO_REARM_EN
    check_eq("hs1_busy", busy, 0);
    pulse_start();
`endif

    // Stop coincident with the 5th tick: that tick is counted.
    wait_ticks(5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    check_eq("co_valid", result_valid, 1);
    check_eq("co_base", result_base, 5);
    check_eq("co_ovf", overflow, 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
`ifndef MEAS_CTRL_AUTO_REARM_EN
    pulse_start();
`endif

    // Overflow with a coincident stop; overflow wins.
    step(); step();
    stub_en = 1'b1; stub_exp = 4'd10; stop = 1'b1;
    step();
    stub_en = 1'b0; stop = 1'b0;
    check_eq("ovf_cnt_en", cnt_en, 0);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_base", result_base, 99);
    check_eq("ovf_exp", result_exp, 9);
    check_eq("ovf_valid", result_valid, 1);

    // Back-pressure: result stays frozen, start ignored.
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      step();
      check_eq("bp_valid", result_valid, 1);
      check_eq("bp_base", result_base, 99);
      check_eq("bp_ovf", overflow, 1);
    end
    start = 1'b0;
    check_eq("bp_exp", result_exp, 9);
    check_eq("bp_cnt_rst", cnt_rst, 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_eq("hs_ovf_valid", result_valid, 0);
    check_eq("hs_ovf_flag", overflow, 0);
`ifdef MEAS_CTRL_AUTO_REARM_EN
    check_eq("hs_ovf_rearm_clr", cnt_rst, 1);
    check_eq("hs_ovf_busy", busy, 1);
`else
    check_eq("hs_ovf_busy", busy, 0);
    pulse_start();
`endif

    // Reset in RUN mid-prescale.
    step(); step();
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_en", cnt_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", result_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("after_rst_valid", result_valid, 0);
      check_eq("after_rst_en", cnt_en, 0);
    end

    // start and stop together in IDLE: start wins, stop dropped.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("ss_cnt_rst", cnt_rst, 1);
    step(); step(); step();
    check_eq("ss_busy", busy, 1);
    check_eq("ss_valid", result_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
